uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin UART transmitter: ack is a same-cycle accept while IDLE, the frame starts on the next baud_tick.
// Requests made during a frame wait unacknowledged until one IDLE cycle after tx_done.
module uart_tx_arbiter #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] ack,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic       owner
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    state_t     state, state_nxt;
    logic [7:0] shift, shift_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       stop_cnt, stop_cnt_nxt;
    logic       tx_nxt;
    logic       tx_done_nxt;
    logic       owner_nxt;
    logic       last_grant, last_grant_nxt;
    logic       grant_idx;
    logic       grant_vld;

    assign busy = (state != IDLE);

    // Grant is held off during the tx_done cycle so frames are separated by one IDLE cycle.
    always_comb begin
        grant_idx = (req == 2'b11) ? ~last_grant : req[1];
        grant_vld = (state == IDLE) && (req != 2'b00) && !tx_done && !reset;
        ack       = 2'b00;
        if (grant_vld) begin
            ack = grant_idx ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_nxt      = state;
        shift_nxt      = shift;
        bit_cnt_nxt    = bit_cnt;
        stop_cnt_nxt   = stop_cnt;
        tx_nxt         = tx;
        tx_done_nxt    = 1'b0;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (grant_vld) begin
                    shift_nxt      = grant_idx ? data1 : data0;
                    owner_nxt      = grant_idx;
                    last_grant_nxt = grant_idx;
                    state_nxt      = ALIGN;
                end
            end
            ALIGN: begin
                if (baud_tick) begin
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_nxt      = shift[0];
                    bit_cnt_nxt = 3'd0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == 3'd7) begin
                        tx_nxt       = 1'b1;
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = STOP;
                    end else begin
                        shift_nxt   = {1'b0, shift[7:1]};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        tx_nxt      = shift[1];
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        tx_done_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        stop_cnt_nxt = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= 8'h00;
            bit_cnt    <= 3'd0;
            stop_cnt   <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            stop_cnt   <= stop_cnt_nxt;
            tx         <= tx_nxt;
            tx_done    <= tx_done_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    ack_onehot_a: assert property (@(posedge clk_in) disable iff (reset) $onehot0(ack));
    ack_idle_a:   assert property (@(posedge clk_in) disable iff (reset) (ack != 2'b00) |-> !busy);

endmodule
